// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared constants and transmitter state type for the RS232 link
// Build option: RS232_TX_PARITY_EN adds an even-parity bit and a PARITY state (11-bit frame).
package rs232_pkg;

    localparam int   DATA_W      = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

`ifdef RS232_TX_PARITY_EN
    localparam int FRAME_BITS = 11;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_STOP   = 3'd3,
        TX_PARITY = 3'd4
    } tx_state_e;
`else
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/rs232_baud_tick.sv
// rtl/rs232_baud_tick.sv - bit-period counter producing one tick per CLKS_PER_BIT cycles
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   clear  - restart the count at 0 on the next edge (wins over enable)
//   enable - count while high; tick is forced low otherwise
//   tick   - high during the last cycle of each bit period
module rs232_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - RS232 byte serialiser with a one-byte holding register
// Build option: RS232_TX_PARITY_EN inserts an even-parity bit between data and stop.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset; aborts any frame and drops the held byte
//   tx_data  - byte to send, sampled on the tx_valid && tx_ready edge
//   tx_valid - byte offered
//   tx_ready - holding register empty (low while reset is high)
//   Tx       - registered serial line, idles high
//   busy     - frame in progress or byte held
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              Tx,
    output logic              busy
);

    localparam logic [2:0] IDLE   = TX_IDLE;
    localparam logic [2:0] START  = TX_START;
    localparam logic [2:0] DATA   = TX_DATA;
    localparam logic [2:0] STOP   = TX_STOP;
`ifdef RS232_TX_PARITY_EN
    localparam logic [2:0] PARITY = TX_PARITY;
`endif

    localparam int            IW       = $clog2(DATA_W);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

    logic [2:0]        state,     state_n;
    logic [DATA_W-1:0] shift_q,   shift_n;
    logic [IW-1:0]     bit_idx,   idx_n;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic              tx_q,      tx_n;
    logic              drain;
    logic              tick;
    logic              cnt_clear;
    logic              cnt_enable;
`ifdef RS232_TX_PARITY_EN
    logic              parity_q;
`endif

    // Counter restarts on every START entry so each frame's start bit is full length,
    // including the STOP->START path of back-to-back frames.
    assign cnt_enable = (state != IDLE);
    assign cnt_clear  = (state_n == START) && (state != START);

    rs232_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .tick   (tick)
    );

    always_comb begin
        state_n = state;
        shift_n = shift_q;
        idx_n   = bit_idx;
        drain   = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    shift_n = hold_data;
                    drain   = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    idx_n   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift_q >> 1;
                    idx_n   = bit_idx + IW'(1);
                    if (bit_idx == LAST_BIT) begin
`ifdef RS232_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef RS232_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // A held byte starts its frame straight after the stop bit.
                    if (hold_full) begin
                        shift_n = hold_data;
                        drain   = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Tx is registered from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        tx_n = IDLE_LEVEL;
        case (state_n)
            START:   tx_n = START_LEVEL;
            DATA:    tx_n = shift_n[0];
`ifdef RS232_TX_PARITY_EN
            PARITY:  tx_n = parity_q;
`endif
            STOP:    tx_n = STOP_LEVEL;
            default: tx_n = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            bit_idx   <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
            tx_q      <= IDLE_LEVEL;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bit_idx <= idx_n;
            tx_q    <= tx_n;
            // Drain wins over load; ready is low while full so both never coincide.
            if (drain) begin
                hold_full <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
        end
    end

`ifdef RS232_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (drain) begin
            parity_q <= ^hold_data;
        end
    end
`endif

    assign tx_ready = !reset && !hold_full;
    assign Tx       = tx_q;
    assign busy     = (state != IDLE) || hold_full;

endmodule

// File: tb/tb_rs232_tx.sv
// tb/tb_rs232_tx.sv - randomized self-checking bench for rs232_tx at CLKS_PER_BIT 1 and 4
module tb_rs232_tx;

`ifdef RS232_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int CPB0 = 1;
    localparam int CPB1 = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] td  [2];
    logic       tv  [2];
    logic       rdy [2];
    logic       txl [2];
    logic       bsy [2];

    int n_checks = 0;
    int n_errors = 0;
    int vprob    = 100;

    // Reference: a held byte becomes a list of line levels, played one per edge.
    logic       fr      [2][48];
    int         flen    [2];
    int         fpos    [2];
    bit         hold_m  [2];
    logic [7:0] hold_b  [2];
    bit         acc     [2];
    logic       exp_tx  [2];
    logic       exp_bsy [2];

    logic [7:0] sq0[$];
    logic [7:0] sq1[$];

    always #5 clk = ~clk;

    rs232_tx #(.CLKS_PER_BIT(CPB0)) dut_c1 (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (td[0]),
        .tx_valid (tv[0]),
        .tx_ready (rdy[0]),
        .Tx       (txl[0]),
        .busy     (bsy[0])
    );

    rs232_tx #(.CLKS_PER_BIT(CPB1)) dut_c4 (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (td[1]),
        .tx_valid (tv[1]),
        .tx_ready (rdy[1]),
        .Tx       (txl[1]),
        .busy     (bsy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cpb(input int i);
        return (i == 0) ? CPB0 : CPB1;
    endfunction

    task automatic push_level(input int i, input logic v);
        for (int k = 0; k < cpb(i); k++) begin
            fr[i][flen[i]] = v;
            flen[i]++;
        end
    endtask

    task automatic build_frame(input int i, input logic [7:0] b);
        fpos[i] = 0;
        flen[i] = 0;
        push_level(i, 1'b0);
        for (int j = 0; j < 8; j++) push_level(i, b[j]);
`ifdef RS232_TX_PARITY_EN
        push_level(i, ^b);
`endif
        push_level(i, 1'b1);
    endtask

    task automatic model_edge(input int i);
        bit rdy_before;
        bit popped;
        acc[i] = 1'b0;
        if (reset) begin
            fpos[i]    = 0;
            flen[i]    = 0;
            hold_m[i]  = 1'b0;
            exp_tx[i]  = 1'b1;
            exp_bsy[i] = 1'b0;
        end else begin
            rdy_before = !hold_m[i];
            if (hold_m[i] && fpos[i] == flen[i]) begin
                build_frame(i, hold_b[i]);
                hold_m[i] = 1'b0;
            end
            popped = 1'b0;
            if (fpos[i] < flen[i]) begin
                exp_tx[i] = fr[i][fpos[i]];
                fpos[i]++;
                popped = 1'b1;
            end else begin
                exp_tx[i] = 1'b1;
            end
            if (tv[i] && rdy_before) begin
                hold_m[i] = 1'b1;
                hold_b[i] = td[i];
                acc[i]    = 1'b1;
            end
            exp_bsy[i] = popped || hold_m[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int i = 0; i < 2; i++) begin
            check((i == 0) ? "tx_cpb1"    : "tx_cpb4",    32'(txl[i]), 32'(exp_tx[i]));
            check((i == 0) ? "busy_cpb1"  : "busy_cpb4",  32'(bsy[i]), 32'(exp_bsy[i]));
            check((i == 0) ? "ready_cpb1" : "ready_cpb4", 32'(rdy[i]), 32'(!reset && !hold_m[i]));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            bit         has;
            logic [7:0] b;
            has = (i == 0) ? (sq0.size() != 0) : (sq1.size() != 0);
            b   = 8'($urandom);
            if (has) b = (i == 0) ? sq0[0] : sq1[0];
            if (has && $urandom_range(0, 99) < vprob) begin
                tv[i] = 1'b1;
                td[i] = b;
            end else begin
                tv[i] = 1'b0;
                td[i] = 8'($urandom);
            end
        end
    endtask

    task automatic pop_accepted();
        if (acc[0] && sq0.size() != 0) void'(sq0.pop_front());
        if (acc[1] && sq1.size() != 0) void'(sq1.pop_front());
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((sq0.size() != 0 || sq1.size() != 0 || exp_bsy[0] || exp_bsy[1]) && n < limit) begin
            drive();
            step();
            pop_accepted();
            n++;
        end
        check("drain_timeout", 32'(n >= limit), 32'(0));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive();
            step();
            pop_accepted();
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            td[i] = 8'hA5;
            tv[i] = 1'b1;
            flen[i] = 0;
            fpos[i] = 0;
            hold_m[i] = 1'b0;
            hold_b[i] = 8'h00;
            acc[i] = 1'b0;
            exp_tx[i] = 1'b1;
            exp_bsy[i] = 1'b0;
        end

        // Reset with valid offered, then valid withdrawn before any transfer.
        repeat (3) step();
        tv = '{1'b0, 1'b0};
        step();
        reset = 1'b0;
        idle_cycles(12);

        // Single bytes: A5 at one clock per bit, 3C at four clocks per bit.
        vprob = 100;
        sq0.push_back(8'hA5);
        sq1.push_back(8'h3C);
        run_until_idle(200);
        idle_cycles(5);

        // Back-to-back with valid held high.
        sq0.push_back(8'h00);
        sq0.push_back(8'hFF);
        sq1.push_back(8'h00);
        sq1.push_back(8'hFF);
        run_until_idle(300);
        idle_cycles(5);

        // Reset during data bit 3 of 81 with a second byte held.
        sq0.push_back(8'h81);
        sq0.push_back(8'h42);
        n = 0;
        while (fpos[0] != 5 && n < 50) begin
            drive();
            step();
            pop_accepted();
            n++;
        end
        check("bit3_timeout", 32'(n >= 50), 32'(0));
        sq0.delete();
        tv = '{1'b0, 1'b0};
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_cycles(30);

        // Random bytes with random valid gaps.
        vprob = 60;
        for (int k = 0; k < 30; k++) begin
            sq0.push_back(8'($urandom));
            sq1.push_back(8'($urandom));
        end
        run_until_idle(3000);

        // Valid held low: line stays idle.
        idle_cycles(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
